// File: rtl/aquila_dev_xbar.sv
`timescale 1ns / 1ps
// aquila_dev_xbar: two-master, NS-slave device-bus interconnect.
// Master 0 is the core device port, master 1 the read-only debug fetch port.
// Each master has a one-entry pending register. Grants are round-robin on ties,
// address decode is table driven, and a transaction ends on slave ready,
// on a decode error, or when it times out.
module aquila_dev_xbar #(
    parameter int unsigned          XLEN    = 32,
    parameter int unsigned          NS      = 4,
    parameter logic [NS*XLEN-1:0]   S_BASE  = {NS{32'h0}},
    parameter logic [NS*XLEN-1:0]   S_MASK  = {NS{32'hFF00_0000}},
    parameter int unsigned          TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // master 0: core device port
    input  logic                 m0_strobe_i,
    input  logic [XLEN-1:0]      m0_addr_i,
    input  logic                 m0_we_i,
    input  logic [XLEN/8-1:0]    m0_be_i,
    input  logic [XLEN-1:0]      m0_wdata_i,
    output logic [XLEN-1:0]      m0_rdata_o,
    output logic                 m0_ready_o,
    output logic                 m0_err_o,
    // master 1: debug fetch port (read-only)
    input  logic                 m1_req_i,
    input  logic [XLEN-1:0]      m1_addr_i,
    output logic [XLEN-1:0]      m1_rdata_o,
    output logic                 m1_ready_o,
    output logic                 m1_err_o,
    // shared slave side
    output logic [NS-1:0]        s_strobe_o,
    output logic [XLEN-1:0]      s_addr_o,
    output logic                 s_we_o,
    output logic [XLEN/8-1:0]    s_be_o,
    output logic [XLEN-1:0]      s_wdata_o,
    input  logic [NS*XLEN-1:0]   s_rdata_i,
    input  logic [NS-1:0]        s_ready_i,
    output logic                 busy_o
);

    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [BW-1:0]   be;
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t           state_q, state_d;
    logic [1:0]       pend_vld_q;
    req_t [1:0]       pend_q;
    logic [1:0]       overflow_q;
    req_t             trans_q;
    logic             gnt_q;
    logic             last_q;
    logic [SW-1:0]    sel_q;
    logic             derr_q;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  rdata_q;
    logic             err_q;

    req_t [1:0]       in_req;
    req_t [1:0]       entry;
    logic [1:0]       in_pulse;
    logic [1:0]       inflight;
    logic [1:0]       acc;
    logic [1:0]       req_eff;
    logic             tie;
    logic             grant_valid;
    logic             grant_m;
    req_t             grant_entry;
    logic             dec_hit;
    logic [SW-1:0]    dec_sel;
    logic             sel_ready;
    logic [XLEN-1:0]  sel_rdata;

    // master 1 is read-only: writes disabled, all byte lanes enabled
    assign in_req[0] = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign in_req[1] = '{addr: m1_addr_i, we: 1'b0, be: '1, wdata: '0};
    assign in_pulse  = {m1_req_i, m0_strobe_i};

    // Accept a pulse only when its master has nothing pending or in flight;
    // an idle FSM sees an accepted pulse the same cycle it arrives.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        inflight = '0;
        if (state_q != IDLE) inflight[gnt_q] = 1'b1;
        acc     = in_pulse & ~pend_vld_q & ~inflight;
        req_eff = pend_vld_q | acc;
        for (int i = 0; i < 2; i++) begin
            entry[i] = pend_vld_q[i] ? pend_q[i] : in_req[i];
        end
        tie         = &req_eff;
        // the tie pointer only moves on contended grants, so successive ties alternate
        grant_m     = tie ? ~last_q : req_eff[1];
        grant_valid = (state_q == IDLE) && (|req_eff);
        grant_entry = entry[grant_m];
    end

    // Address decode of the entry being granted; lowest matching index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = int'(NS) - 1; i >= 0; i--) begin
            if ((grant_entry.addr & S_MASK[i*XLEN +: XLEN]) == S_BASE[i*XLEN +: XLEN]) begin
                dec_hit = 1'b1;
                dec_sel = SW'(i);
            end
        end
    end

    // Ready/read-data mux of the selected slave; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NS); i++) begin
            if (sel_q == SW'(i)) begin
                sel_ready = s_ready_i[i];
                sel_rdata = s_rdata_i[i*XLEN +: XLEN];
            end
        end
    end

    // Per-master pending entries and sticky overflow flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the payload is reset together with its valid bit because it is a single flop entry, not a RAM; this keeps every output at 0 after reset.
            pend_vld_q <= '0;
            pend_q     <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant_valid && (grant_m == 1'(i))) begin
                    pend_vld_q[i] <= 1'b0;
                end else if (acc[i]) begin
                    pend_vld_q[i] <= 1'b1;
                    pend_q[i]     <= in_req[i];
                end
                if (in_pulse[i] && !acc[i]) overflow_q[i] <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (grant_valid) state_d = ISSUE;
            ISSUE: state_d = derr_q ? RESP : WAIT;
            WAIT:  if (sel_ready || (cnt_q == CW'(TIMEOUT))) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction register, timeout counter and response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trans_q <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b0;
            sel_q   <= '0;
            derr_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        trans_q <= grant_entry;
                        gnt_q   <= grant_m;
                        sel_q   <= dec_sel;
                        derr_q  <= ~dec_hit;
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= ~dec_hit;
                        if (tie) last_q <= grant_m;
                    end
                end
                WAIT: begin
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-hot slave strobe for the single ISSUE cycle of a decoded transaction.
    always_comb begin
        s_strobe_o = '0;
        if ((state_q == ISSUE) && !derr_q) begin
            for (int i = 0; i < int'(NS); i++) begin
                if (sel_q == SW'(i)) s_strobe_o[i] = 1'b1;
            end
        end
    end

    assign s_addr_o   = trans_q.addr;
    assign s_we_o     = trans_q.we;
    assign s_be_o     = trans_q.be;
    assign s_wdata_o  = trans_q.wdata;

    // responses come only from registers, never straight from the slave inputs
    assign m0_ready_o = (state_q == RESP) && !gnt_q;
    assign m1_ready_o = (state_q == RESP) &&  gnt_q;
    assign m0_rdata_o = m0_ready_o ? rdata_q : '0;
    assign m1_rdata_o = m1_ready_o ? rdata_q : '0;
    assign m0_err_o   = m0_ready_o & err_q;
    assign m1_err_o   = m1_ready_o & err_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_aquila_dev_xbar.sv
`timescale 1ns / 1ps
// Scoreboard bench for aquila_dev_xbar: stimulus pushes expected strobes and
// responses into queues, two monitors pop and compare on the falling edge.
module tb_aquila_dev_xbar;

    localparam int XLEN    = 32;
    localparam int NS      = 3;
    localparam int TIMEOUT = 8;
    localparam logic [NS*XLEN-1:0] S_BASE = {32'hCD00_0000, 32'hC200_0000, 32'hC000_0000};
    localparam logic [NS*XLEN-1:0] S_MASK = {3{32'hFF00_0000}};

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              m0_strobe, m0_we, m0_ready, m0_err;
    logic [31:0]       m0_addr, m0_wdata, m0_rdata;
    logic [3:0]        m0_be;
    logic              m1_req, m1_ready, m1_err;
    logic [31:0]       m1_addr, m1_rdata;
    logic [2:0]        s_strobe, s_ready;
    logic [31:0]       s_addr, s_wdata;
    logic              s_we;
    logic [3:0]        s_be;
    logic [NS*XLEN-1:0] s_rdata;
    logic              busy;
    logic              sl0_rdy = 1'b0, sl1_rdy = 1'b0, sl2_rdy = 1'b0;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          m;
        logic [31:0] rdata;
        logic        err;
        int          cy;
    } resp_t;

    typedef struct {
        logic [2:0]  stb;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cy;
    } stb_t;

    resp_t resp_q[$];
    stb_t  stb_q[$];

    aquila_dev_xbar #(
        .XLEN(XLEN), .NS(NS), .S_BASE(S_BASE), .S_MASK(S_MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_strobe_i(m0_strobe), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_ready_o(m0_ready), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr),
        .m1_rdata_o(m1_rdata), .m1_ready_o(m1_ready), .m1_err_o(m1_err),
        .s_strobe_o(s_strobe), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_ready_i(s_ready), .busy_o(busy)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // slaves 0 and 2 answer the cycle after their strobe; slave 1 is driven by the stimulus
    always @(posedge clk_i) begin
        sl0_rdy <= s_strobe[0];
        sl2_rdy <= s_strobe[2];
    end
    assign s_ready = {sl2_rdy, sl1_rdy, sl0_rdy};
    assign s_rdata = {32'h1234_5678, 32'hDEAD_0001, 32'h5A5A_0000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_strobe(input logic [2:0] stb, input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wd, input int cy);
        stb_t e;
        e.stb = stb; e.addr = addr; e.we = we; e.be = be; e.wdata = wd; e.cy = cy;
        stb_q.push_back(e);
    endtask

    task automatic exp_resp(input bit m, input logic [31:0] rd, input logic err, input int cy);
        resp_t e;
        e.m = m; e.rdata = rd; e.err = err; e.cy = cy;
        resp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic p0, input logic p1, input logic [31:0] a0, input logic we0,
                         input logic [3:0] be0, input logic [31:0] wd0, input logic [31:0] a1);
        m0_strobe = p0; m0_addr = a0; m0_we = we0; m0_be = be0; m0_wdata = wd0;
        m1_req    = p1; m1_addr = a1;
        step();
        m0_strobe = 1'b0;
        m1_req    = 1'b0;
    endtask

    // wait, bounded, until every expected event has been seen and the block is idle
    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0 || stb_q.size() != 0 || busy) && n < 60) begin
            step();
            n++;
        end
        check("drain_left", 64'(resp_q.size() + stb_q.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
        step();
    endtask

    // response monitor
    always @(negedge clk_i) begin
        resp_t e;
        if (rst_ni && (m0_ready || m1_ready)) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 64'({m1_ready, m0_ready}), 64'd0);
            end else begin
                e = resp_q.pop_front();
                check("resp_who", 64'({m1_ready, m0_ready}), e.m ? 64'd2 : 64'd1);
                check("resp_rdata", 64'(e.m ? m1_rdata : m0_rdata), 64'(e.rdata));
                check("resp_err", 64'(e.m ? m1_err : m0_err), 64'(e.err));
                check("resp_cycle", 64'(cyc), 64'(e.cy));
                check("resp_other_quiet", e.m ? 64'({m0_err, m0_rdata}) : 64'({m1_err, m1_rdata}), 64'd0);
            end
        end
    end

    // slave strobe monitor
    always @(negedge clk_i) begin
        stb_t e;
        if (rst_ni && (s_strobe != 3'b000)) begin
            if (stb_q.size() == 0) begin
                check("strobe_unexpected", 64'(s_strobe), 64'd0);
            end else begin
                e = stb_q.pop_front();
                check("strobe_sel", 64'(s_strobe), 64'(e.stb));
                check("strobe_addr", 64'(s_addr), 64'(e.addr));
                check("strobe_we", 64'(s_we), 64'(e.we));
                check("strobe_be", 64'(s_be), 64'(e.be));
                check("strobe_wdata", 64'(s_wdata), 64'(e.wdata));
                check("strobe_cycle", 64'(cyc), 64'(e.cy));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_ni = 1'b0;
        m0_strobe = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_be = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobe", 64'(s_strobe), 64'd0);
        check("rst_s_fields", 64'({s_we, s_be, s_addr}), 64'd0);
        check("rst_m_outputs", 64'({m0_ready, m0_err, m1_ready, m1_err}), 64'd0);
        rst_ni = 1'b1;
        step(); step();

        // basic read from slave 2, minimum latency
        c = cyc;
        exp_strobe(3'b100, 32'hCD00_0010, 1'b0, 4'hF, 32'h0, c + 1);
        exp_resp(1'b0, 32'h1234_5678, 1'b0, c + 3);
        pulse(1'b1, 1'b0, 32'hCD00_0010, 1'b0, 4'hF, 32'h0, 32'h0);
        drain();

        // write to slave 0, request fields hold afterwards
        c = cyc;
        exp_strobe(3'b001, 32'hC000_0004, 1'b1, 4'b0011, 32'hAABB_CCDD, c + 1);
        exp_resp(1'b0, 32'h5A5A_0000, 1'b0, c + 3);
        pulse(1'b1, 1'b0, 32'hC000_0004, 1'b1, 4'b0011, 32'hAABB_CCDD, 32'h0);
        drain();
        check("hold_fields", 64'({s_we, s_be, s_addr}), 64'({1'b1, 4'b0011, 32'hC000_0004}));
        check("hold_wdata", 64'(s_wdata), 64'h0000_0000_AABB_CCDD);

        // first tie: master 1 wins, master 0 follows
        c = cyc;
        exp_strobe(3'b100, 32'hCD00_0040, 1'b0, 4'hF, 32'h0, c + 1);
        exp_resp(1'b1, 32'h1234_5678, 1'b0, c + 3);
        exp_strobe(3'b100, 32'hCD00_0020, 1'b0, 4'hF, 32'h1111_2222, c + 5);
        exp_resp(1'b0, 32'h1234_5678, 1'b0, c + 7);
        pulse(1'b1, 1'b1, 32'hCD00_0020, 1'b0, 4'hF, 32'h1111_2222, 32'hCD00_0040);
        drain();

        // second tie: master 0 wins
        c = cyc;
        exp_strobe(3'b100, 32'hCD00_0020, 1'b0, 4'hF, 32'h1111_2222, c + 1);
        exp_resp(1'b0, 32'h1234_5678, 1'b0, c + 3);
        exp_strobe(3'b100, 32'hCD00_0040, 1'b0, 4'hF, 32'h0, c + 5);
        exp_resp(1'b1, 32'h1234_5678, 1'b0, c + 7);
        pulse(1'b1, 1'b1, 32'hCD00_0020, 1'b0, 4'hF, 32'h1111_2222, 32'hCD00_0040);
        drain();

        // unmapped address: no strobe, error response at cycle 2
        c = cyc;
        exp_resp(1'b0, 32'h0, 1'b1, c + 2);
        pulse(1'b1, 1'b0, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h0);
        drain();

        // timeout on slave 1, a dropped second pulse, a late ready that is ignored
        c = cyc;
        exp_strobe(3'b010, 32'hC200_0008, 1'b0, 4'hF, 32'h0, c + 1);
        exp_resp(1'b0, 32'h0, 1'b1, c + 11);
        pulse(1'b1, 1'b0, 32'hC200_0008, 1'b0, 4'hF, 32'h0, 32'h0);
        step(); step();
        pulse(1'b1, 1'b0, 32'hC200_00FF, 1'b0, 4'hF, 32'h0, 32'h0);
        while (cyc < c + 12) step();
        sl1_rdy = 1'b1;
        step(); step();
        sl1_rdy = 1'b0;
        check("overflow_m0", 64'(dut.overflow_q[0]), 64'd1);
        check("overflow_m1", 64'(dut.overflow_q[1]), 64'd0);
        drain();

        // reset while waiting on slave 1: everything clears, no stale response
        c = cyc;
        exp_strobe(3'b010, 32'hC200_0000, 1'b0, 4'hF, 32'h0, c + 1);
        pulse(1'b1, 1'b0, 32'hC200_0000, 1'b0, 4'hF, 32'h0, 32'h0);
        step(); step(); step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_s_fields", 64'({s_strobe, s_we, s_be, s_addr}), 64'd0);
        check("mid_rst_wdata", 64'(s_wdata), 64'd0);
        check("mid_rst_m_outputs", 64'({m0_ready, m0_err, m0_rdata}), 64'd0);
        check("mid_rst_overflow", 64'(dut.overflow_q), 64'd0);
        step(); step();
        rst_ni = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("post_rst_idle", 64'(busy), 64'd0);

        c = cyc;
        exp_strobe(3'b100, 32'hCD00_0010, 1'b0, 4'hF, 32'h0, c + 1);
        exp_resp(1'b0, 32'h1234_5678, 1'b0, c + 3);
        pulse(1'b1, 1'b0, 32'hCD00_0010, 1'b0, 4'hF, 32'h0, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
